// File: rtl/beep_pkg.sv
// Shared types, defaults and prescaler helpers for the beep sequencer.
package beep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int unsigned DEF_CLK_HZ  = 50_000_000;
    localparam int unsigned DEF_TICK_HZ = 1000;
    localparam int unsigned DEF_DIV_W   = 16;
    localparam int unsigned DEF_DUR_W   = 12;
    localparam int unsigned DEF_CNT_W   = 4;

    // Clock cycles per duration tick; never below 1.
    function automatic int unsigned tick_div(input int unsigned clk_hz, input int unsigned tick_hz);
        return (clk_hz / tick_hz == 0) ? 1 : clk_hz / tick_hz;
    endfunction

    // Prescaler counter width; at least one bit.
    function automatic int unsigned tick_w(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/beep_seq_if.sv
// Request handshake and buzzer status bundle for beep_seq.
interface beep_seq_if
    import beep_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W,
    parameter int unsigned DUR_W = DEF_DUR_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) ();
    logic             req_valid;
    logic             req_ready;
    logic [DIV_W-1:0] req_half;
    logic [DUR_W-1:0] req_on;
    logic [DUR_W-1:0] req_off;
    logic [CNT_W-1:0] req_count;
    logic             beep_out;
    logic             busy;
    logic             done;

    modport master (
        output req_valid, req_half, req_on, req_off, req_count,
        input  req_ready, beep_out, busy, done
    );

    modport slave (
        input  req_valid, req_half, req_on, req_off, req_count,
        output req_ready, beep_out, busy, done
    );
endinterface

// File: rtl/beep_tick_gen.sv
// Duration-tick prescaler: one-cycle tick every DIV clocks, restartable.
module beep_tick_gen
    import beep_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int unsigned W = tick_w(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/beep_seq.sv
// Programmable buzzer sequencer: tone bursts, gaps, repeat count, done pulse.
// BEEP_RETRIGGER_EN: accept requests while busy, restarting the pattern.
module beep_seq
    import beep_pkg::*;
#(
    parameter int unsigned CLK_HZ  = DEF_CLK_HZ,
    parameter int unsigned TICK_HZ = DEF_TICK_HZ,
    parameter int unsigned DIV_W   = DEF_DIV_W,
    parameter int unsigned DUR_W   = DEF_DUR_W,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input logic       clk,
    input logic       rst,
    beep_seq_if.slave bus
);
    localparam int unsigned TICK_DIV = tick_div(CLK_HZ, TICK_HZ);

    state_e           state, state_nxt;
    logic [DIV_W-1:0] half_q, div_q, div_nxt;
    logic [DUR_W-1:0] on_last_q, off_last_q, dur_q;
    logic             gap_en_q;
    logic [CNT_W-1:0] bursts_q;
    logic             tone_lvl, lvl_nxt;
    logic             tick, accept_c, phase_end_c, entry_c;
    logic             beep_nxt, busy_nxt, done_nxt, ready_nxt;

    assign accept_c    = bus.req_valid && bus.req_ready;
    assign phase_end_c = tick && ((state == ST_TONE && dur_q == on_last_q) ||
                                  (state == ST_GAP  && dur_q == off_last_q));
    // Any fresh start of a burst, including TONE->TONE when there is no gap.
    assign entry_c     = accept_c || (phase_end_c && state_nxt == ST_TONE);

    beep_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (accept_c || phase_end_c),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = ST_IDLE;
            ST_TONE: begin
                if (phase_end_c) begin
                    if (bursts_q == CNT_W'(1)) state_nxt = ST_IDLE;
                    else if (gap_en_q)         state_nxt = ST_GAP;
                    else                       state_nxt = ST_TONE;
                end
            end
            ST_GAP:  if (phase_end_c) state_nxt = ST_TONE;
            default: state_nxt = ST_IDLE;
        endcase
        if (accept_c) state_nxt = ST_TONE;
    end

    always_comb begin
        beep_nxt = 1'b1;
        busy_nxt = (state_nxt != ST_IDLE);
        done_nxt = (state != ST_IDLE) && (state_nxt == ST_IDLE);
`ifdef BEEP_RETRIGGER_EN
        ready_nxt = 1'b1;
`else
        ready_nxt = (state_nxt == ST_IDLE);
`endif
        if (state_nxt == ST_TONE) beep_nxt = lvl_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.beep_out  <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.req_ready <= 1'b1;
        end else begin
            bus.beep_out  <= beep_nxt;
            bus.busy      <= busy_nxt;
            bus.done      <= done_nxt;
            bus.req_ready <= ready_nxt;
        end
    end

    // Square-wave divider; every burst starts high with a cleared divider.
    always_comb begin
        div_nxt = div_q;
        lvl_nxt = tone_lvl;
        if (entry_c) begin
            div_nxt = '0;
            lvl_nxt = 1'b1;
        end else if (state == ST_TONE) begin
            if (div_q == half_q) begin
                div_nxt = '0;
                lvl_nxt = ~tone_lvl;
            end else begin
                div_nxt = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_q     <= '0;
            on_last_q  <= '0;
            off_last_q <= '0;
            gap_en_q   <= 1'b0;
            bursts_q   <= '0;
            dur_q      <= '0;
            div_q      <= '0;
            tone_lvl   <= 1'b1;
        end else begin
            div_q    <= div_nxt;
            tone_lvl <= lvl_nxt;
            if (accept_c) begin
                half_q     <= bus.req_half;
                on_last_q  <= (bus.req_on == '0) ? '0 : bus.req_on - DUR_W'(1);
                off_last_q <= bus.req_off - DUR_W'(1);
                gap_en_q   <= (bus.req_off != '0);
                bursts_q   <= (bus.req_count == '0) ? CNT_W'(1) : bus.req_count;
            end else if (state == ST_TONE && phase_end_c) begin
                bursts_q <= bursts_q - CNT_W'(1);
            end
            if (accept_c || phase_end_c) dur_q <= '0;
            else if (tick && state != ST_IDLE) dur_q <= dur_q + DUR_W'(1);
        end
    end
endmodule
